// File: rtl/common_pkg.sv
// Shared constants and types for the NoC datapath blocks.
package common_pkg;

  // Default flit width used across the NoC datapath.
  localparam int unsigned DEFAULT_D_W = 8;

  // Four-input round-robin arbiter.
  localparam int unsigned ARB4_N      = 4;
  localparam int unsigned ARB4_L      = $clog2(ARB4_N);
  localparam int unsigned GRANT_CNT_W = 16;

  typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t;

endpackage

// File: rtl/mux.sv
// Generic N:1 mux selecting one W-bit word from a packed input vector.
module mux #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned L = (N > 1) ? $clog2(N) : 1
) (
  input  logic [L-1:0]        i_sel,
  input  logic [N-1:0][W-1:0] i_data,
  output logic [W-1:0]        o_data
);

  // Plain indexed select.
  always_comb begin
    o_data = i_data[i_sel];
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four requesters starting at i_ptr.
module rr_pick4
  import common_pkg::*;
(
  input  logic [ARB4_N-1:0] i_valid,
  input  logic [ARB4_L-1:0] i_ptr,
  output logic [ARB4_L-1:0] o_gidx,
  output logic [ARB4_N-1:0] o_gnt,
  output logic              o_any
);

  logic [ARB4_L-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest valid from i_ptr wins.
  always_comb begin
    o_gidx = '0;
    w_idx  = '0;
    for (int k = ARB4_N - 1; k >= 0; k--) begin
      w_idx = i_ptr + ARB4_L'(k);
      if (i_valid[w_idx]) begin
        o_gidx = w_idx;
      end
    end
    o_any = |i_valid;
    o_gnt = o_any ? (ARB4_N'(1) << o_gidx) : '0;
  end

endmodule

// File: rtl/noc_rr_arb4.sv
// Four-input round-robin arbitration stage with a registered output flit.
// Optional per-requester grant counters are built when NOC_RR_ARB_GRANT_CNT_EN
// is defined.
module noc_rr_arb4
  import common_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ARB4_N-1:0]                  i_valid,
  input  logic [ARB4_N-1:0][DEFAULT_D_W-1:0] i_data,
  output logic [ARB4_N-1:0]                  i_ready,
  output logic                               o_valid,
  output logic [DEFAULT_D_W-1:0]             o_data,
  input  logic                               o_ready,
  output logic [ARB4_L-1:0]                  o_sel
`ifdef NOC_RR_ARB_GRANT_CNT_EN
  ,
  output logic [ARB4_N-1:0][GRANT_CNT_W-1:0] o_grant_cnt
`endif
);

  arb_state_t             r_state;
  logic [ARB4_L-1:0]      r_ptr;
  logic [DEFAULT_D_W-1:0] r_data;
  logic [ARB4_L-1:0]      r_sel;

  logic [ARB4_L-1:0]      w_gidx;
  logic [ARB4_N-1:0]      w_gnt;
  logic                   w_any;
  logic                   w_can_load;
  logic                   w_load;
  logic [DEFAULT_D_W-1:0] w_flit;

  rr_pick4 u_pick (
    .i_valid (i_valid),
    .i_ptr   (r_ptr),
    .o_gidx  (w_gidx),
    .o_gnt   (w_gnt),
    .o_any   (w_any)
  );

  mux #(
    .N (ARB4_N),
    .W (DEFAULT_D_W)
  ) u_mux (
    .i_sel  (w_gidx),
    .i_data (i_data),
    .o_data (w_flit)
  );

  // Output slot is free when empty or when its flit leaves this cycle.
  always_comb begin
    w_can_load = (r_state == ARB_EMPTY) || o_ready;
    w_load     = w_can_load && w_any;
    // rst_n gate keeps i_ready low for the whole reset, not just after the edge.
    i_ready    = (w_can_load && rst_n) ? w_gnt : '0;
  end

  // Output register FSM; priority pointer moves only on an actual load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_sel   <= '0;
    end else begin
      if (w_load) begin
        r_state <= ARB_FULL;
        r_data  <= w_flit;
        r_sel   <= w_gidx;
        r_ptr   <= w_gidx + ARB4_L'(1);
      end else if ((r_state == ARB_FULL) && o_ready) begin
        r_state <= ARB_EMPTY;
      end
    end
  end

  assign o_valid = (r_state == ARB_FULL);
  assign o_data  = r_data;
  assign o_sel   = r_sel;

`ifdef NOC_RR_ARB_GRANT_CNT_EN
  logic [ARB4_N-1:0][GRANT_CNT_W-1:0] r_cnt;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_load && (r_cnt[w_gidx] != {GRANT_CNT_W{1'b1}})) begin
      r_cnt[w_gidx] <= r_cnt[w_gidx] + GRANT_CNT_W'(1);
    end
  end

  assign o_grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_noc_rr_arb4.sv
// Directed bench for noc_rr_arb4 with hand-computed expectations.
module tb_noc_rr_arb4;

  logic            clk;
  logic            rst_n;
  logic [3:0]      i_valid;
  logic [3:0][7:0] i_data;
  logic [3:0]      i_ready;
  logic            o_valid;
  logic [7:0]      o_data;
  logic            o_ready;
  logic [1:0]      o_sel;
`ifdef NOC_RR_ARB_GRANT_CNT_EN
  logic [3:0][15:0] o_grant_cnt;
`endif

  int n_vec;
  int n_err;

  noc_rr_arb4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_ready     (o_ready),
    .o_sel       (o_sel)
`ifdef NOC_RR_ARB_GRANT_CNT_EN
    ,
    .o_grant_cnt (o_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq [6];

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b1;
    o_ready = 1'b0;
    i_valid = 4'b1111;
    for (int k = 0; k < 4; k++) i_data[k] = 8'h10 + 8'(k);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_i_ready", 32'(i_ready), 32'h0);
    check_eq("rst_o_valid", 32'(o_valid), 32'h0);
    check_eq("rst_o_data",  32'(o_data),  32'h0);
    check_eq("rst_o_sel",   32'(o_sel),   32'h0);
    i_valid = 4'b0000;
    o_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Idle: nothing requested for 5 cycles.
    for (int c = 0; c < 5; c++) begin
      check_eq("idle_i_ready", 32'(i_ready), 32'h0);
      tick();
      check_eq("idle_o_valid", 32'(o_valid), 32'h0);
    end

    // Single request on input 2; pointer was 0, so it must still find input 2.
    i_valid   = 4'b0100;
    i_data[2] = 8'hA5;
    #1;
    check_eq("single_i_ready", 32'(i_ready), 32'h4);
    tick();
    i_valid   = 4'b0000;
    i_data[2] = 8'h12;
    check_eq("single_o_valid", 32'(o_valid), 32'h1);
    check_eq("single_o_data",  32'(o_data),  32'hA5);
    check_eq("single_o_sel",   32'(o_sel),   32'h2);
    tick();
    check_eq("drain_o_valid", 32'(o_valid), 32'h0);

    // All four requesting; pointer is now 3.
    seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd1;
    seq[3] = 2'd2; seq[4] = 2'd3; seq[5] = 2'd0;
    i_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      #1;
      check_eq("rr_i_ready", 32'(i_ready), 32'(4'b0001 << seq[g]));
      tick();
      check_eq("rr_o_valid", 32'(o_valid), 32'h1);
      check_eq("rr_o_sel",   32'(o_sel),   32'(seq[g]));
      check_eq("rr_o_data",  32'(o_data),  32'h10 + 32'(seq[g]));
    end

    // Load 0x11 from input 1, then stall for 3 cycles.
    tick();
    check_eq("bp_setup_data", 32'(o_data), 32'h11);
    o_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("bp_i_ready", 32'(i_ready), 32'h0);
      tick();
      check_eq("bp_o_valid", 32'(o_valid), 32'h1);
      check_eq("bp_o_data",  32'(o_data),  32'h11);
      check_eq("bp_o_sel",   32'(o_sel),   32'h1);
    end
    o_ready = 1'b1;
    #1;
    check_eq("bp_release_i_ready", 32'(i_ready), 32'h4);
    tick();
    check_eq("bp_release_o_sel",  32'(o_sel),  32'h2);
    check_eq("bp_release_o_data", 32'(o_data), 32'h12);

    // Wrap-around: pointer 3, requesters 3 and 0.
    i_valid = 4'b1001;
    #1;
    check_eq("wrap_i_ready3", 32'(i_ready), 32'h8);
    tick();
    check_eq("wrap_o_sel3", 32'(o_sel), 32'h3);
    check_eq("wrap_i_ready0", 32'(i_ready), 32'h1);
    tick();
    check_eq("wrap_o_sel0",  32'(o_sel),  32'h0);
    check_eq("wrap_o_data0", 32'(o_data), 32'h10);

    // FULL -> EMPTY when downstream accepts and nothing is requested.
    i_valid = 4'b0000;
    tick();
    check_eq("empty_o_valid", 32'(o_valid), 32'h0);

    // Stall while FULL (pointer left at 1), then reset mid-transfer.
    i_valid = 4'b1111;
    tick();
    o_ready = 1'b0;
    tick();
    check_eq("pre_rst_o_sel", 32'(o_sel), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_o_valid", 32'(o_valid), 32'h0);
    check_eq("mid_rst_o_data",  32'(o_data),  32'h0);
    check_eq("mid_rst_i_ready", 32'(i_ready), 32'h0);
    i_valid = 4'b0000;
    o_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    i_valid = 4'b1111;
    #1;
    check_eq("post_rst_i_ready", 32'(i_ready), 32'h1);
    tick();
    check_eq("post_rst_o_sel", 32'(o_sel), 32'h0);
    check_eq("post_rst_o_valid", 32'(o_valid), 32'h1);

`ifdef NOC_RR_ARB_GRANT_CNT_EN
    // Reset clears the counters, then input 1 alone is granted every cycle.
    i_valid = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    check_eq("cnt_rst", 32'(o_grant_cnt[1]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    i_valid = 4'b0010;
    for (int c = 0; c < 65534; c++) tick();
    check_eq("cnt_fffe", 32'(o_grant_cnt[1]), 32'hFFFE);
    for (int c = 0; c < 3; c++) tick();
    check_eq("cnt_sat",  32'(o_grant_cnt[1]), 32'hFFFF);
    check_eq("cnt_other", 32'(o_grant_cnt[0]), 32'h0);
    i_valid = 4'b0000;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
